alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
Parametrised successor to the 8-bit combinational ALU. It adds a registered result, status flags, a valid/ready input handshake and iterative multi-cycle shift and multiply operations. It sits between the register file and the writeback mux of the UL8 datapath. The control unit issues one operation at a time and waits for done_out.

Parameters:
WIDTH, 8, operand/result width in bits; power of two, ≥ 2
SHW, $clog2(WIDTH), localparam; shift-amount width taken from y_in

Ports:
clk_in  input  1  clock, rising edge
rst_n_in  input  1  asynchronous active-low reset
x_in  input  WIDTH  operand x
y_in  input  WIDTH  operand y (shift amount = y_in[SHW-1:0])
op_in  input  3  operation select
valid_in  input  1  request valid
ready_out  output  1  block idle, request will be accepted
z_out  output  WIDTH  registered result
done_out  output  1  one-cycle pulse: z_out/flags updated this cycle
zero_out  output  1  z_out == 0
carry_out  output  1  carry/borrow/shift-out/overflow (per op)
neg_out  output  1  z_out[WIDTH-1]

Behaviour:
- Reset (async, rst_n_in=0): state IDLE; z_out=0, done_out=0, zero_out=0, carry_out=0, neg_out=0, ready_out=1. Reset mid-operation aborts the operation. No done_out is produced for the aborted operation.
- Accept: valid_in && ready_out at a rising edge. x_in, y_in and op_in are latched. valid_in while ready_out=0 is ignored, not queued.
- ready_out = (state == IDLE). On the edge that completes an operation, the FSM returns to IDLE, so back-to-back single-cycle ops issue every cycle.
- Ops (mod 2^WIDTH):
  - 000 ADD: z=x+y; carry=carry-out.
  - 001 NAND: z=~(x&y); carry=0.
  - 010 NOT: z=~x; carry=0.
  - 011 CLR: z=0; carry=0.
  - 100 SUB: z=x-y; carry=borrow (x<y unsigned).
  - 101 SHL: logical left shift by n=y[SHW-1:0], one bit per cycle; carry=last bit shifted out (0 if n=0).
  - 110 SHR: logical right shift, same rules as SHL.
  - 111 MUL: unsigned shift-add, one bit of y per cycle, WIDTH iterations; z=low WIDTH bits; carry=1 if high WIDTH bits ≠ 0.
- FSM states: IDLE, SHIFT, MUL.
  - IDLE → SHIFT on accepting SHL/SHR with n ≥ 2.
  - IDLE → MUL on accepting MUL.
  - SHIFT/MUL → IDLE on the final iteration edge.
- Latency: edge count from the accept edge to the edge where done_out rises, inclusive of the accept edge.
  - Single-cycle ops and shifts with n ≤ 1: 1.
  - Shift: max(n,1).
  - MUL: WIDTH.
  - ready_out is low for latency−1 cycles.
- done_out is high for exactly one cycle. z_out and flags update only on that cycle and hold otherwise.
- zero_out and neg_out are derived from the new z value and registered with it.
- Intermediate shift/MUL values are never visible on z_out.

Optional Feature:
ALU_SEQ_MUL_EN.
- Defined: MUL state and multiplier datapath are present, as above.
- Undefined: MUL logic is removed. op 111 completes in 1 cycle with z=0, zero_out=1, carry_out=1 (illegal-op marker), and the FSM never enters MUL.

Test Plan:
- WIDTH=8, x=0x20, y=0x0D:
  - ADD → z=0x2D, carry=0, done 1 cycle after accept.
  - NAND → 0xFF.
  - NOT → 0xDF.
  - CLR → 0x00, zero=1.
- ADD x=0xFF, y=0x01 → z=0x00, zero=1, carry=1.
- SUB x=0x0D, y=0x20 → z=0xED, carry=1, neg=1.
- SHL x=0x0D, y=0x03 → z=0x68, carry=0, done 3 cycles after accept, ready_out low 2 cycles.
  - A valid_in with ADD pulsed while busy produces no extra done_out.
  - SHR x=0x81, y=0x01 → z=0x40, carry=1, 1 cycle.
- MUL x=0x0D, y=0x20 → z=0xA0, carry=1, done after 8 cycles.
  - MUL 0x03*0x05 → 0x0F, carry=0.
  - With ALU_SEQ_MUL_EN undefined: op 111 → z=0, zero=1, carry=1 after 1 cycle.
- Assert rst_n_in low 4 cycles into a MUL → all outputs immediately at reset values, ready_out=1, no done_out.
  - An ADD accepted right after reset release completes normally.

Source files
------------

// File: rtl/alu_seq_if.sv
// alu_seq_if: request/result bundle between the UL8 control unit and alu_seq.
//   master : control unit side  (drives x_in, y_in, op_in, valid_in;
//                                 observes ready_out, z_out, done_out and flags)
//   slave  : alu_seq side        (the opposite directions)
// Parameter WIDTH sets the operand/result width and must match the ALU.
`timescale 1ns/1ps
interface alu_seq_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] x_in;
  logic [WIDTH-1:0] y_in;
  logic [2:0]       op_in;
  logic             valid_in;
  logic             ready_out;
  logic [WIDTH-1:0] z_out;
  logic             done_out;
  logic             zero_out;
  logic             carry_out;
  logic             neg_out;

  modport master (
    output x_in, y_in, op_in, valid_in,
    input  ready_out, z_out, done_out, zero_out, carry_out, neg_out
  );

  modport slave (
    input  x_in, y_in, op_in, valid_in,
    output ready_out, z_out, done_out, zero_out, carry_out, neg_out
  );
endinterface

// File: rtl/alu_seq.sv
// alu_seq: sequential ALU with registered result and status flags.
//   clk_in    : rising-edge clock
//   rst_n_in  : asynchronous active-low reset, aborts any operation in flight
//   bus       : alu_seq_if.slave -- x_in/y_in/op_in/valid_in request with
//               ready_out, z_out, done_out pulse and zero/carry/neg flags
// Ops: ADD NAND NOT CLR SUB complete in one cycle; SHL/SHR shift one bit per
// cycle (y_in[SHW-1:0] places); MUL is an unsigned shift-add over WIDTH cycles.
// Build option: define ALU_SEQ_MUL_EN to include the multiplier. Without it,
// op 111 finishes in one cycle with z=0 and carry=1 as an illegal-op marker.
`timescale 1ns/1ps
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic     clk_in,
  input  logic     rst_n_in,
  alu_seq_if.slave bus
);
  localparam int SHW = $clog2(WIDTH);

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_NAND = 3'b001;
  localparam logic [2:0] OP_NOT  = 3'b010;
  localparam logic [2:0] OP_CLR  = 3'b011;
  localparam logic [2:0] OP_SUB  = 3'b100;
  localparam logic [2:0] OP_SHL  = 3'b101;
  localparam logic [2:0] OP_SHR  = 3'b110;
  localparam logic [2:0] OP_MUL  = 3'b111;

  typedef enum logic [1:0] {IDLE, SHIFT, MUL} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] z_q, z_d;
  logic             carry_q, carry_d;
  logic             zero_q, neg_q;
  logic             done_q, done_d;

  // Iterative shift working registers
  logic [WIDTH-1:0] shf_q, shf_d;
  logic             dir_q, dir_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [SHW-1:0]   n;
  logic [WIDTH:0]   sh_step, sh_first;

`ifdef ALU_SEQ_MUL_EN
  logic [2*WIDTH-1:0] prod_q, prod_d, prod_add;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
`endif

  // One-place logical shift; returns {bit shifted out, shifted value}
  function automatic logic [WIDTH:0] shift1(input logic [WIDTH-1:0] v,
                                            input logic right);
    if (right) shift1 = {v[0], 1'b0, v[WIDTH-1:1]};
    else       shift1 = {v[WIDTH-1], v[WIDTH-2:0], 1'b0};
  endfunction

  assign n = bus.y_in[SHW-1:0];

  always_comb begin
    state_d  = state_q;
    done_d   = 1'b0;
    z_d      = '0;
    carry_d  = 1'b0;
    shf_d    = shf_q;
    dir_d    = dir_q;
    cnt_d    = cnt_q;
    sh_step  = shift1(shf_q, dir_q);
    sh_first = shift1(bus.x_in, (bus.op_in == OP_SHR));
`ifdef ALU_SEQ_MUL_EN
    prod_d   = prod_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prod_add = prod_q + (mplier_q[0] ? mcand_q : '0);
`endif
    unique case (state_q)
      IDLE: begin
        if (bus.valid_in) begin
          done_d = 1'b1;
          unique case (bus.op_in)
            OP_ADD:  {carry_d, z_d} = {1'b0, bus.x_in} + {1'b0, bus.y_in};
            OP_NAND: z_d = ~(bus.x_in & bus.y_in);
            OP_NOT:  z_d = ~bus.x_in;
            OP_CLR:  z_d = '0;
            // Borrow falls out as the top bit of the extended difference
            OP_SUB:  {carry_d, z_d} = {1'b0, bus.x_in} - {1'b0, bus.y_in};
            OP_SHL, OP_SHR: begin
              if (n == '0) begin
                z_d = bus.x_in;
              end else if (n == SHW'(1)) begin
                {carry_d, z_d} = sh_first;
              end else begin
                // The accept edge already performs the first shift place
                done_d  = 1'b0;
                state_d = SHIFT;
                {dir_d} = (bus.op_in == OP_SHR);
                shf_d   = sh_first[WIDTH-1:0];
                cnt_d   = n - SHW'(1);
              end
            end
            OP_MUL: begin
`ifdef ALU_SEQ_MUL_EN
              // Accept edge consumes multiplier bit 0
              done_d   = 1'b0;
              state_d  = MUL;
              prod_d   = bus.y_in[0] ? {{WIDTH{1'b0}}, bus.x_in} : '0;
              mcand_d  = {{(WIDTH-1){1'b0}}, bus.x_in, 1'b0};
              mplier_d = {1'b0, bus.y_in[WIDTH-1:1]};
              cnt_d    = SHW'(WIDTH - 1);
`else
              z_d     = '0;
              carry_d = 1'b1;
`endif
            end
            default: z_d = '0;
          endcase
        end
      end
      SHIFT: begin
        shf_d = sh_step[WIDTH-1:0];
        cnt_d = cnt_q - SHW'(1);
        if (cnt_q == SHW'(1)) begin
          done_d         = 1'b1;
          {carry_d, z_d} = sh_step;
          state_d        = IDLE;
        end
      end
`ifdef ALU_SEQ_MUL_EN
      MUL: begin
        prod_d   = prod_add;
        mcand_d  = {mcand_q[2*WIDTH-2:0], 1'b0};
        mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
        cnt_d    = cnt_q - SHW'(1);
        if (cnt_q == SHW'(1)) begin
          done_d  = 1'b1;
          z_d     = prod_add[WIDTH-1:0];
          carry_d = |prod_add[2*WIDTH-1:WIDTH];
          state_d = IDLE;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // Control and visible result: z/flags only move on a completion cycle
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
      z_q     <= '0;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
      neg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      if (done_d) begin
        z_q     <= z_d;
        carry_q <= carry_d;
        zero_q  <= (z_d == '0);
        neg_q   <= z_d[WIDTH-1];
      end
    end
  end

  // Working registers: only meaningful while busy, so no reset needed
  always_ff @(posedge clk_in) begin
    shf_q <= shf_d;
    dir_q <= dir_d;
    cnt_q <= cnt_d;
`ifdef ALU_SEQ_MUL_EN
    prod_q   <= prod_d;
    mcand_q  <= mcand_d;
    mplier_q <= mplier_d;
`endif
  end

  assign bus.ready_out = (state_q == IDLE);
  assign bus.z_out     = z_q;
  assign bus.done_out  = done_q;
  assign bus.zero_out  = zero_q;
  assign bus.carry_out = carry_q;
  assign bus.neg_out   = neg_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: self-checking bench for alu_seq (WIDTH=8). Expected results come
// from a plain-arithmetic reference model; honours ALU_SEQ_MUL_EN if defined.
`timescale 1ns/1ps
module tb_alu_seq;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic [W-1:0] prev_z = '0;

  alu_seq_if #(.WIDTH(W)) bus ();

  alu_seq #(.WIDTH(W)) dut (
    .clk_in   (clk),
    .rst_n_in (rst_n),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: result, carry flag and latency in edges
  task automatic model(input logic [2:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                       output logic [W-1:0] z, output logic c, output int lat);
    int xi, yi, n, r;
    xi = int'(x);
    yi = int'(y);
    n  = yi % W;
    lat = 1;
    c = 1'b0;
    r = 0;
    case (op)
      3'd0: begin r = xi + yi; c = (r > 255); end
      3'd1: r = 255 - (xi & yi);
      3'd2: r = 255 - xi;
      3'd3: r = 0;
      3'd4: begin r = (xi - yi + 256) % 256; c = (xi < yi); end
      3'd5: begin
        r = (xi * (1 << n)) % 256;
        c = (n == 0) ? 1'b0 : 1'(((xi * (1 << n)) / 256) % 2);
        lat = (n < 1) ? 1 : n;
      end
      3'd6: begin
        r = xi / (1 << n);
        c = (n == 0) ? 1'b0 : 1'((xi / (1 << (n - 1))) % 2);
        lat = (n < 1) ? 1 : n;
      end
      default: begin
`ifdef ALU_SEQ_MUL_EN
        r = (xi * yi) % 256;
        c = ((xi * yi) > 255);
        lat = W;
`else
        r = 0;
        c = 1'b1;
`endif
      end
    endcase
    z = W'(r);
  endtask

  // Issue one op from an idle cycle (called at posedge+1) and check completion
  task automatic run_op(input string tag, input logic [2:0] op, input logic [W-1:0] x,
                        input logic [W-1:0] y, input bit pulse_busy);
    logic [W-1:0] ez;
    logic ec;
    int lat, cyc;
    model(op, x, y, ez, ec, lat);
    chk({tag, ".ready_idle"}, 32'(bus.ready_out), 32'd1);
    bus.x_in = x;
    bus.y_in = y;
    bus.op_in = op;
    bus.valid_in = 1'b1;
    @(posedge clk); #1;
    bus.valid_in = 1'b0;
    cyc = 1;
    while (bus.done_out !== 1'b1 && cyc < 40) begin
      chk({tag, ".ready_busy"}, 32'(bus.ready_out), 32'd0);
      chk({tag, ".z_hold"}, 32'(bus.z_out), 32'(prev_z));
      if (pulse_busy) begin
        bus.op_in = 3'd0;
        bus.x_in = 8'h11;
        bus.y_in = 8'h22;
        bus.valid_in = 1'b1;
      end
      @(posedge clk); #1;
      cyc++;
    end
    bus.valid_in = 1'b0;
    chk({tag, ".done"}, 32'(bus.done_out), 32'd1);
    chk({tag, ".latency"}, 32'(cyc), 32'(lat));
    chk({tag, ".z"}, 32'(bus.z_out), 32'(ez));
    chk({tag, ".carry"}, 32'(bus.carry_out), 32'(ec));
    chk({tag, ".zero"}, 32'(bus.zero_out), 32'(ez == '0));
    chk({tag, ".neg"}, 32'(bus.neg_out), 32'(ez[W-1]));
    prev_z = ez;
    @(posedge clk); #1;
    chk({tag, ".done_pulse"}, 32'(bus.done_out), 32'd0);
    chk({tag, ".z_after"}, 32'(bus.z_out), 32'(ez));
  endtask

  initial begin
    logic [2:0] rop;
    logic [W-1:0] rx, ry;
    bus.x_in = '0;
    bus.y_in = '0;
    bus.op_in = '0;
    bus.valid_in = 1'b0;

    // Reset state
    #1;
    chk("rst.z", 32'(bus.z_out), 32'd0);
    chk("rst.done", 32'(bus.done_out), 32'd0);
    chk("rst.zero", 32'(bus.zero_out), 32'd0);
    chk("rst.carry", 32'(bus.carry_out), 32'd0);
    chk("rst.neg", 32'(bus.neg_out), 32'd0);
    chk("rst.ready", 32'(bus.ready_out), 32'd1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed cases
    run_op("add", 3'd0, 8'h20, 8'h0D, 1'b0);
    run_op("nand", 3'd1, 8'h20, 8'h0D, 1'b0);
    run_op("not", 3'd2, 8'h20, 8'h0D, 1'b0);
    run_op("clr", 3'd3, 8'h20, 8'h0D, 1'b0);
    run_op("add_wrap", 3'd0, 8'hFF, 8'h01, 1'b0);
    run_op("sub_borrow", 3'd4, 8'h0D, 8'h20, 1'b0);
    run_op("shl3_busy", 3'd5, 8'h0D, 8'h03, 1'b1);
    run_op("shr1", 3'd6, 8'h81, 8'h01, 1'b0);
    run_op("shl0", 3'd5, 8'hA5, 8'h08, 1'b0);
    run_op("shr7", 3'd6, 8'hC0, 8'h07, 1'b0);
    run_op("mul_a", 3'd7, 8'h0D, 8'h20, 1'b1);
    run_op("mul_b", 3'd7, 8'h03, 8'h05, 1'b0);

    // Back-to-back single-cycle ops
    bus.op_in = 3'd0;
    bus.x_in = 8'h01;
    bus.y_in = 8'h02;
    bus.valid_in = 1'b1;
    @(posedge clk); #1;
    chk("b2b.done1", 32'(bus.done_out), 32'd1);
    chk("b2b.z1", 32'(bus.z_out), 32'h03);
    chk("b2b.ready", 32'(bus.ready_out), 32'd1);
    bus.x_in = 8'h05;
    bus.y_in = 8'h06;
    @(posedge clk); #1;
    bus.valid_in = 1'b0;
    chk("b2b.done2", 32'(bus.done_out), 32'd1);
    chk("b2b.z2", 32'(bus.z_out), 32'h0B);
    prev_z = 8'h0B;
    @(posedge clk); #1;
    chk("b2b.idle", 32'(bus.done_out), 32'd0);

    // Reset asserted four cycles into a long operation
`ifdef ALU_SEQ_MUL_EN
    bus.op_in = 3'd7;
    bus.y_in = 8'h07;
`else
    bus.op_in = 3'd5;
    bus.y_in = 8'h07;
`endif
    bus.x_in = 8'h09;
    bus.valid_in = 1'b1;
    @(posedge clk); #1;
    bus.valid_in = 1'b0;
    repeat (3) begin
      chk("abort.busy", 32'(bus.ready_out), 32'd0);
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    chk("abort.z", 32'(bus.z_out), 32'd0);
    chk("abort.done", 32'(bus.done_out), 32'd0);
    chk("abort.zero", 32'(bus.zero_out), 32'd0);
    chk("abort.carry", 32'(bus.carry_out), 32'd0);
    chk("abort.neg", 32'(bus.neg_out), 32'd0);
    chk("abort.ready", 32'(bus.ready_out), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    prev_z = '0;
    repeat (8) begin
      chk("abort.no_done", 32'(bus.done_out), 32'd0);
      @(posedge clk); #1;
    end
    run_op("post_rst_add", 3'd0, 8'h20, 8'h0D, 1'b0);

    // Randomised ops against the model
    for (int i = 0; i < 40; i++) begin
      rop = 3'($urandom_range(0, 7));
      rx = 8'($urandom);
      ry = 8'($urandom);
      run_op("rand", rop, rx, ry, 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
